// File: rtl/mode_key_ctrl.sv
// mode_key_ctrl: debounced key front end and OFFLINE/ONLINE/SET mode FSM with timed SET sessions
module mode_key_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_online,
    input  logic       key_set,
    output logic       online,
    output logic       set,
    output logic [1:0] set_sel,
    output logic       set_commit,
    output logic       set_abort
);
    typedef enum logic [1:0] {ST_OFFLINE, ST_ONLINE, ST_SET} state_t;

    // Bit 0 carries key_online, bit 1 carries key_set throughout the conditioning path.
    logic [1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]  stable_q, stable_d, stable_prev_q, stable_prev_d;
    logic [19:0] cnt_q [2];
    logic [19:0] cnt_d [2];
    logic [1:0]  press;
    logic        po, ps;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] tmo_q, tmo_d;
    logic        commit_q, commit_d, abort_q, abort_d;

    // Synchronise both keys and accept a level only after it has held for DEBOUNCE_CYCLES.
    always_comb begin
        sync1_d       = {key_set, key_online};
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (cnt_q[k] + 20'd1 == DEBOUNCE_CYCLES)
                    stable_d[k] = sync2_q[k];
                else
                    cnt_d[k] = cnt_q[k] + 20'd1;
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;
    assign po    = press[0];
    assign ps    = press[1];

    // Mode transitions; simultaneous presses freeze everything, including the timeout count.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        commit_d = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            ST_OFFLINE: begin
                if (po && !ps) begin
                    state_d = ST_ONLINE;
                end else if (ps && !po) begin
                    state_d = ST_SET;
                    sel_d   = 2'd0;
                    tmo_d   = '0;
                end
            end
            ST_ONLINE: begin
                if (po && !ps)
                    state_d = ST_OFFLINE;
            end
            ST_SET: begin
                if (!(po && ps)) begin
                    if (po) begin
                        state_d = ST_OFFLINE;
                        sel_d   = 2'd0;
                        tmo_d   = '0;
                        abort_d = 1'b1;
                    end else if (ps) begin
                        tmo_d = '0;
                        if (sel_q == 2'd2) begin
                            state_d  = ST_OFFLINE;
                            sel_d    = 2'd0;
                            commit_d = 1'b1;
                        end else begin
                            sel_d = sel_q + 2'd1;
                        end
                    end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                        state_d = ST_OFFLINE;
                        sel_d   = 2'd0;
                        tmo_d   = '0;
                        abort_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = ST_OFFLINE;
                sel_d   = 2'd0;
                tmo_d   = '0;
            end
        endcase
    end

    // All state registers; reset discards any in-flight debounce or session.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '{default: '0};
            state_q       <= ST_OFFLINE;
            sel_q         <= 2'd0;
            tmo_q         <= '0;
            commit_q      <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            sel_q         <= sel_d;
            tmo_q         <= tmo_d;
            commit_q      <= commit_d;
            abort_q       <= abort_d;
        end
    end

    assign online     = (state_q == ST_ONLINE);
    assign set        = (state_q == ST_SET);
    assign set_sel    = sel_q;
    assign set_commit = commit_q;
    assign set_abort  = abort_q;
endmodule

// File: tb/tb_mode_key_ctrl.sv
// tb_mode_key_ctrl: directed vector table plus hand sequences for mode_key_ctrl
module tb_mode_key_ctrl;
    logic       clk = 1'b0;
    logic       rst, key_online, key_set;
    logic       online, set, set_commit, set_abort;
    logic [1:0] set_sel;
    int         errs = 0, checks = 0, n_commit = 0, n_abort = 0;

    typedef struct {
        logic       ko;
        logic       ks;
        int         n;
        logic       eon;
        logic       eset;
        logic [1:0] esel;
    } vec_t;
    vec_t tbl[$];

    mode_key_ctrl #(.DEBOUNCE_CYCLES(20'd4), .TIMEOUT_CYCLES(32'd50)) dut (
        .clk(clk), .rst(rst), .key_online(key_online), .key_set(key_set),
        .online(online), .set(set), .set_sel(set_sel),
        .set_commit(set_commit), .set_abort(set_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse accounting and output exclusivity on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_commit += int'(set_commit);
            n_abort  += int'(set_abort);
            checks++;
            if ((online && set) || (set_commit && set_abort)) begin
                errs++;
                $display("FAIL exclusivity: online=%0b set=%0b commit=%0b abort=%0b", online, set, set_commit, set_abort);
            end
        end
    end

    initial begin
        rst = 1'b1; key_online = 1'b0; key_set = 1'b0;
        wait_n(3);
        chk("rst online", online, 0);
        chk("rst set", set, 0);
        chk("rst sel", set_sel, 0);
        chk("rst commit", set_commit, 0);
        chk("rst abort", set_abort, 0);
        rst = 1'b0;
        wait_n(3);
        // First press latency: outputs move at edge DEBOUNCE+3 = 7.
        key_online = 1'b1;
        wait_n(6);
        chk("t1 online@6", online, 0);
        wait_n(1);
        chk("t1 online@7", online, 1);
        chk("t1 set@7", set, 0);
        wait_n(13);
        tbl.push_back('{0, 0, 20, 1, 0, 0});
        tbl.push_back('{1, 0, 20, 0, 0, 0});
        tbl.push_back('{0, 0, 20, 0, 0, 0});
        tbl.push_back('{0, 1,  3, 0, 0, 0});
        tbl.push_back('{0, 0, 10, 0, 0, 0});
        tbl.push_back('{0, 1, 10, 0, 1, 0});
        tbl.push_back('{0, 0, 10, 0, 1, 0});
        tbl.push_back('{0, 1, 10, 0, 1, 1});
        tbl.push_back('{0, 0, 10, 0, 1, 1});
        tbl.push_back('{0, 1, 10, 0, 1, 2});
        tbl.push_back('{0, 0, 10, 0, 1, 2});
        tbl.push_back('{0, 1, 10, 0, 0, 0});
        tbl.push_back('{0, 0, 10, 0, 0, 0});
        tbl.push_back('{1, 0, 10, 1, 0, 0});
        tbl.push_back('{0, 0, 10, 1, 0, 0});
        tbl.push_back('{0, 1, 10, 1, 0, 0});
        tbl.push_back('{0, 0, 10, 1, 0, 0});
        tbl.push_back('{1, 0, 10, 0, 0, 0});
        tbl.push_back('{0, 0, 10, 0, 0, 0});
        tbl.push_back('{1, 1, 10, 0, 0, 0});
        tbl.push_back('{0, 0, 10, 0, 0, 0});
        tbl.push_back('{0, 1, 10, 0, 1, 0});
        tbl.push_back('{0, 0, 10, 0, 1, 0});
        tbl.push_back('{0, 1, 10, 0, 1, 1});
        tbl.push_back('{0, 0, 10, 0, 1, 1});
        tbl.push_back('{0, 1, 10, 0, 1, 2});
        tbl.push_back('{0, 0, 10, 0, 1, 2});
        foreach (tbl[i]) begin
            key_online = tbl[i].ko;
            key_set    = tbl[i].ks;
            wait_n(tbl[i].n);
            chk($sformatf("v%0d online", i), online, tbl[i].eon);
            chk($sformatf("v%0d set", i), set, tbl[i].eset);
            chk($sformatf("v%0d sel", i), set_sel, tbl[i].esel);
        end
        chk("commit count", n_commit, 1);
        chk("abort count", n_abort, 0);
        // Reset in the middle of a key_set debounce while at set_sel=2.
        key_set = 1'b1;
        wait_n(5);
        rst = 1'b1; key_set = 1'b0;
        #1;
        chk("t6 rst set", set, 0);
        chk("t6 rst sel", set_sel, 0);
        chk("t6 rst online", online, 0);
        wait_n(2);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            wait_n(1);
            chk($sformatf("t6 idle%0d state", c), {online, set, set_sel, set_commit, set_abort}, 0);
        end
        // Timeout after exactly TIMEOUT_CYCLES cycles in SET.
        key_set = 1'b1;
        wait_n(7);
        chk("t4 enter set", set, 1);
        wait_n(3);
        key_set = 1'b0;
        wait_n(46);
        chk("t4 set@49", set, 1);
        chk("t4 abort@49", set_abort, 0);
        wait_n(1);
        chk("t4 set@50", set, 0);
        chk("t4 abort@50", set_abort, 1);
        wait_n(1);
        chk("t4 abort@51", set_abort, 0);
        // Press at cycle 40 restarts the timeout.
        wait_n(5);
        key_set = 1'b1;
        wait_n(7);
        chk("t4b enter set", set, 1);
        wait_n(3);
        key_set = 1'b0;
        wait_n(30);
        key_set = 1'b1;
        wait_n(7);
        chk("t4b sel@40", set_sel, 1);
        wait_n(3);
        key_set = 1'b0;
        wait_n(46);
        chk("t4b set@89", set, 1);
        chk("t4b sel@89", set_sel, 1);
        wait_n(1);
        chk("t4b set@90", set, 0);
        chk("t4b sel@90", set_sel, 0);
        chk("t4b abort@90", set_abort, 1);
        wait_n(3);
        chk("final commit count", n_commit, 1);
        chk("final abort count", n_abort, 2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
